// File: rtl/seg7_scan_display_pkg.sv
// Shared definitions for the seven-segment scan display: register map,
// control-word layout and small helpers.
package seg7_scan_display_pkg;

  localparam logic [1:0] SEG_ADDR_LO   = 2'b00;
  localparam logic [1:0] SEG_ADDR_HI   = 2'b01;
  localparam logic [1:0] SEG_ADDR_CTRL = 2'b10;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_BLANK_BIT = 1;
  localparam int CTRL_DP_LSB    = 8;

  localparam logic [15:0] CTRL_RESET = 16'h0001;

  // Active-low one-hot digit enable for the selected digit.
  function automatic logic [7:0] digit_enable(input logic [2:0] idx);
    return ~(8'b0000_0001 << idx);
  endfunction

endpackage

// File: rtl/seg7_scan_display_if.sv
// CPU IO-bus write port of the seven-segment display (store side only).
interface seg7_scan_display_if;
  logic        segwrite;
  logic        segcs;
  logic [1:0]  segaddr;
  logic [15:0] segwdata;

  modport master (output segwrite, output segcs, output segaddr, output segwdata);
  modport slave  (input  segwrite, input  segcs, input  segaddr, input  segwdata);
endinterface

// File: rtl/seg7_scan_display_hex7seg.sv
// Combinational hex nibble to active-low seven-segment pattern, [0]=a .. [6]=g.
module seg7_scan_display_hex7seg (
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'h40;
    case (i_nib)
      4'h0: o_seg = 7'h40;
      4'h1: o_seg = 7'h79;
      4'h2: o_seg = 7'h24;
      4'h3: o_seg = 7'h30;
      4'h4: o_seg = 7'h19;
      4'h5: o_seg = 7'h12;
      4'h6: o_seg = 7'h02;
      4'h7: o_seg = 7'h78;
      4'h8: o_seg = 7'h00;
      4'h9: o_seg = 7'h10;
      4'hA: o_seg = 7'h08;
      4'hB: o_seg = 7'h03;
      4'hC: o_seg = 7'h46;
      4'hD: o_seg = 7'h21;
      4'hE: o_seg = 7'h06;
      4'hF: o_seg = 7'h0E;
      default: o_seg = 7'h40;
    endcase
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Memory-mapped eight-digit common-anode display driver: holds a 32-bit value
// and control word, scans one digit every SCAN_DIV clocks, registered pins.
module seg7_scan_display
  import seg7_scan_display_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int DIGITS   = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  seg7_scan_display_if.slave   bus,
  output logic [7:0]           seg_en,
  output logic [7:0]           seg_out
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [15:0]      r_val_lo;
  logic [15:0]      r_val_hi;
  logic             r_ctrl_en;
  logic             r_ctrl_blank;
  logic [7:0]       r_dp_mask;
  logic [CNT_W-1:0] r_cnt_p0;
  logic [IDX_W-1:0] r_idx_p0;
  logic [7:0]       r_seg_en_p1;
  logic [7:0]       r_seg_out_p1;

  logic             w_wr;
  logic [31:0]      w_val;
  logic [3:0]       w_nib;
  logic [6:0]       w_hex;
  logic             w_blank;
  logic             w_last;

  assign w_wr   = bus.segwrite & bus.segcs;
  assign w_val  = {r_val_hi, r_val_lo};
  assign w_nib  = w_val[{r_idx_p0, 2'b00} +: 4];
  assign w_last = (r_cnt_p0 == CNT_W'(SCAN_DIV - 1));

  // A digit is a leading zero when it and every digit to its left are zero.
  assign w_blank = r_ctrl_blank && (r_idx_p0 != '0) &&
                   ((w_val >> {r_idx_p0, 2'b00}) == 32'd0);

  seg7_scan_display_hex7seg u_hex (
    .i_nib (w_nib),
    .o_seg (w_hex)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_val_lo     <= '0;
      r_val_hi     <= '0;
      r_ctrl_en    <= CTRL_RESET[CTRL_EN_BIT];
      r_ctrl_blank <= CTRL_RESET[CTRL_BLANK_BIT];
      r_dp_mask    <= CTRL_RESET[CTRL_DP_LSB +: 8];
    end else if (w_wr) begin
      case (bus.segaddr)
        SEG_ADDR_LO: r_val_lo <= bus.segwdata;
        SEG_ADDR_HI: r_val_hi <= bus.segwdata;
        SEG_ADDR_CTRL: begin
          r_ctrl_en    <= bus.segwdata[CTRL_EN_BIT];
          r_ctrl_blank <= bus.segwdata[CTRL_BLANK_BIT];
          r_dp_mask    <= bus.segwdata[CTRL_DP_LSB +: 8];
        end
        default: ;
      endcase
    end
  end

  // Stage p0: scan counter and digit index
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt_p0 <= '0;
      r_idx_p0 <= '0;
    end else if (w_last) begin
      r_cnt_p0 <= '0;
      r_idx_p0 <= r_idx_p0 + IDX_W'(1);
    end else begin
      r_cnt_p0 <= r_cnt_p0 + CNT_W'(1);
    end
  end

  // Stage p1: registered pin drive from the current digit
  always_ff @(posedge clock) begin
    if (reset || !r_ctrl_en || w_blank) begin
      r_seg_en_p1  <= 8'hFF;
      r_seg_out_p1 <= 8'hFF;
    end else begin
      r_seg_en_p1  <= digit_enable(r_idx_p0);
      r_seg_out_p1 <= {~r_dp_mask[r_idx_p0], w_hex};
    end
  end

  assign seg_en  = r_seg_en_p1;
  assign seg_out = r_seg_out_p1;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display: per-cycle scoreboard from a behavioural model
// plus table-driven digit checks with literal pin patterns.
module tb_seg7_scan_display;

  localparam int SD = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] seg_en;
  logic [7:0] seg_out;

  seg7_scan_display_if bus ();

  seg7_scan_display #(.SCAN_DIV(SD), .DIGITS(8)) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .seg_en  (seg_en),
    .seg_out (seg_out)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] en;
    logic [7:0] seg;
  } exp_t;

  typedef struct {
    int         idx;
    logic [7:0] en;
    logic [7:0] seg;
  } vec_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int          m_cnt, m_idx, last_idx;
  logic [15:0] m_lo, m_hi, m_ctrl;
  logic [7:0]  hexp[16];

  vec_t t2[8];
  vec_t t3[8];
  vec_t t3b[6];
  vec_t t4[4];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got en/seg=%h required %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model_out();
    exp_t        e;
    logic [31:0] v;
    bit          blank;
    v     = {m_hi, m_lo};
    blank = 1'b0;
    if (m_ctrl[1] && m_idx >= 1) begin
      blank = 1'b1;
      for (int k = m_idx; k < 8; k++)
        if (v[4*k +: 4] != 4'h0) blank = 1'b0;
    end
    if (!m_ctrl[0] || blank) begin
      e.en  = 8'hFF;
      e.seg = 8'hFF;
    end else begin
      e.en         = 8'hFF;
      e.en[m_idx]  = 1'b0;
      e.seg        = hexp[v[4*m_idx +: 4]];
      e.seg[7]     = ~m_ctrl[8+m_idx];
    end
    return e;
  endfunction

  task automatic step(input logic rst, input logic w, input logic cs,
                      input logic [1:0] a, input logic [15:0] d);
    exp_t e;
    reset        = rst;
    bus.segwrite = w;
    bus.segcs    = cs;
    bus.segaddr  = a;
    bus.segwdata = d;
    if (rst) begin
      e.en     = 8'hFF;
      e.seg    = 8'hFF;
      last_idx = -1;
    end else begin
      e        = model_out();
      last_idx = (m_ctrl[0]) ? m_idx : -1;
    end
    sbq.push_back(e);
    if (rst) begin
      m_cnt = 0; m_idx = 0; m_lo = 16'h0; m_hi = 16'h0; m_ctrl = 16'h0001;
    end else begin
      if (w && cs) begin
        case (a)
          2'b00: m_lo = d;
          2'b01: m_hi = d;
          2'b10: m_ctrl = d & 16'hFF03;
          default: ;
        endcase
      end
      if (m_cnt == SD - 1) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % 8;
      end else begin
        m_cnt++;
      end
    end
    @(posedge clock);
    #1;
    e = sbq.pop_front();
    check("scan", {seg_en, seg_out}, e);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000);
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    step(1'b0, 1'b1, 1'b1, a, d);
  endtask

  task automatic expect_digit(input string name, input int d,
                              input logic [7:0] en, input logic [7:0] seg);
    bit found = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      idle();
      if (last_idx == d) found = 1'b1;
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: digit %0d never selected, got en/seg=%h required %h", name, d,
               {seg_en, seg_out}, {en, seg});
    end else begin
      check(name, {seg_en, seg_out}, {en, seg});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    hexp = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    t2  = '{'{0, 8'hFE, 8'h99}, '{1, 8'hFD, 8'hB0}, '{2, 8'hFB, 8'hA4}, '{3, 8'hF7, 8'hF9},
            '{4, 8'hEF, 8'h80}, '{5, 8'hDF, 8'hF8}, '{6, 8'hBF, 8'h82}, '{7, 8'h7F, 8'h92}};
    t3  = '{'{0, 8'hFE, 8'hC0}, '{1, 8'hFD, 8'h88}, '{2, 8'hFF, 8'hFF}, '{3, 8'hFF, 8'hFF},
            '{4, 8'hFF, 8'hFF}, '{5, 8'hFF, 8'hFF}, '{6, 8'hFF, 8'hFF}, '{7, 8'hFF, 8'hFF}};
    t3b = '{'{2, 8'hFB, 8'hC0}, '{3, 8'hF7, 8'hC0}, '{4, 8'hEF, 8'hC0},
            '{5, 8'hDF, 8'hC0}, '{6, 8'hBF, 8'hC0}, '{7, 8'h7F, 8'hC0}};
    t4  = '{'{0, 8'hFE, 8'h40}, '{1, 8'hFD, 8'hC0}, '{2, 8'hFB, 8'h40}, '{3, 8'hF7, 8'hC0}};
    m_cnt = 0; m_idx = 0; m_lo = 16'h0; m_hi = 16'h0; m_ctrl = 16'h0001; last_idx = -1;

    // Reset and first digit
    step(1'b1, 1'b0, 1'b0, 2'b00, 16'h0000);
    step(1'b1, 1'b0, 1'b0, 2'b00, 16'h0000);
    check("reset_pins", {seg_en, seg_out}, 16'hFFFF);
    idle();
    check("first_digit", {seg_en, seg_out}, 16'hFEC0);
    for (int i = 0; i < 8; i++) idle();

    // Value display over a full frame
    wr(2'b00, 16'h1234);
    wr(2'b01, 16'h5678);
    for (int i = 0; i < 8; i++) expect_digit("value_frame", t2[i].idx, t2[i].en, t2[i].seg);

    // Leading-zero blanking on and off
    wr(2'b00, 16'h00A0);
    wr(2'b01, 16'h0000);
    wr(2'b10, 16'h0003);
    for (int i = 0; i < 8; i++) expect_digit("blank_on", t3[i].idx, t3[i].en, t3[i].seg);
    wr(2'b10, 16'h0001);
    for (int i = 0; i < 6; i++) expect_digit("blank_off", t3b[i].idx, t3b[i].en, t3b[i].seg);

    // Decimal points
    wr(2'b00, 16'h0000);
    wr(2'b10, 16'h0501);
    for (int i = 0; i < 4; i++) expect_digit("dp_mask", t4[i].idx, t4[i].en, t4[i].seg);

    // Write gating: no chip select, reserved address
    step(1'b0, 1'b1, 1'b0, 2'b00, 16'hFFFF);
    step(1'b0, 1'b1, 1'b0, 2'b10, 16'h0000);
    step(1'b0, 1'b1, 1'b1, 2'b11, 16'hFFFF);
    expect_digit("gated_write", 0, 8'hFE, 8'h40);
    wr(2'b10, 16'h0000);
    idle();
    check("disable", {seg_en, seg_out}, 16'hFFFF);
    for (int i = 0; i < 5; i++) idle();
    wr(2'b10, 16'h0001);
    for (int i = 0; i < 12; i++) idle();

    // Reset mid-scan beats a simultaneous write
    wr(2'b00, 16'h0123);
    begin
      bit hit = 1'b0;
      for (int t = 0; t < 40 && !hit; t++) begin
        if (m_idx == 5 && m_cnt == 2) hit = 1'b1;
        else idle();
      end
      if (!hit) begin
        n_checks++;
        n_fail++;
        $display("FAIL midscan_reach: index 5 count 2 not reached, got en/seg=%h required %h",
                 {seg_en, seg_out}, 16'hDFC0);
      end
    end
    step(1'b1, 1'b1, 1'b1, 2'b00, 16'hFFFF);
    check("midscan_reset", {seg_en, seg_out}, 16'hFFFF);
    idle();
    check("post_reset_d0", {seg_en, seg_out}, 16'hFEC0);
    for (int i = 0; i < 3; i++) idle();
    idle();
    check("post_reset_d1", {seg_en, seg_out}, 16'hFDC0);
    for (int i = 0; i < 8; i++) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
- Memory-mapped eight-digit seven-segment display driver on the CPU IO bus, in parallel with the LED output block.
- Accepts CPU store data via a write-enable/chip-select/sub-address handshake, holds a 32-bit display value plus a control word, and time-multiplexes eight common-anode digits.
- Drives board pins directly; all outputs are registered.

Parameters:
- SCAN_DIV, 100000: clock cycles each digit stays lit. Must be ≥2.
- DIGITS, 8: number of digits. Fixed at 8; other values are unsupported.

Ports:
- clock  input  1  system clock (same clock as the LED block)
- reset  input  1  synchronous, active-high reset
- segwrite  input  1  write strobe from MemOrIO, active high
- segcs  input  1  chip select; a write takes effect only when segwrite&segcs
- segaddr  input  2  register select: 00 low value, 01 high value, 10 control, 11 reserved
- segwdata  input  16  write data (low half of the CPU store data)
- seg_en  output  8  digit enables, active-low; bit i = digit i (digit 0 rightmost)
- seg_out  output  8  segments, active-low; [0]=a … [6]=g, [7]=dp

Behaviour:
- Registers:
  - val_lo[15:0] holds digits 3..0 (nibble per digit).
  - val_hi[15:0] holds digits 7..4.
  - ctrl[15:0]: bit0 = enable, bit1 = blank leading zeros, bits[15:8] = dp mask (bit 8+i lights the dp on digit i), other bits reserved (write ignored, read as 0).
- Write:
  - On the rising edge with segwrite=1 and segcs=1, the addressed register loads segwdata.
  - addr 11 is ignored. segwrite with segcs=0 is ignored.
- Reset, sampled on a clock edge with reset=1:
  - val_lo=val_hi=0; ctrl=16'h0001 (enabled, no blanking, no dp).
  - Scan counter=0; digit index=0.
  - seg_en=8'hFF, seg_out=8'hFF.
  - Reset overrides a simultaneous write.
- Scan:
  - Counter counts 0..SCAN_DIV-1 and wraps to 0.
  - When counter==SCAN_DIV-1, the digit index increments and wraps from 7 to 0.
  - Each digit is active for exactly SCAN_DIV cycles; the full frame is 8*SCAN_DIV cycles.
- Output register: each cycle, seg_en/seg_out load from the current digit index i and the current register contents (1-cycle latency).
  - If enable=0 or digit i is blanked: seg_en=8'hFF, seg_out=8'hFF.
  - Otherwise: seg_en = all ones except bit i = 0; seg_out[6:0] = hex pattern of nibble i; seg_out[7] = ~dp_mask[i].
- Write visibility: a write at edge N is visible on the pins at edge N+1 if the written digit is currently selected. A write does not reset or disturb the scan counter.
- Blanking: when bit1=1, digit i (i≥1) is blanked iff nibbles i..7 are all zero. Digit 0 is never blanked (value 0 shows a single "0"). A dp-mask bit does not unblank a digit.
- Hex patterns (active-low, dp excluded):
  - 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8
  - 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E
  - The dp bit is then applied on top of these values.
- At most one digit enable is low in any cycle; no ghost cycle with two digits enabled.

Decomposition:
- Shared definitions file: register sub-address constants (SEG_ADDR_LO/HI/CTRL), ctrl bit positions, reset value of ctrl.
- Sub-module hex7seg: combinational 4-bit → 7-bit active-low decoder, instantiated once on the selected nibble.

Test Plan (SCAN_DIV=4):
1. Reset: hold reset 2 cycles, release → seg_en=FF and seg_out=FF during reset; first edge after release gives seg_en=FE, seg_out=C0; index advances every 4 cycles.
2. Write: addr 00 ← 0x1234, addr 01 ← 0x5678 → over one frame, digits 0..7 show 99, B0, A4, F9, 80, F8, 82, 92 with enables FE, FD, … 7F.
3. Blanking: val=0x000000A0, ctrl=0x0003 → digit0 C0, digit1 88, digits 2..7 seg_en=FF; with ctrl=0x0001, digits 2..7 show C0.
4. Decimal points: ctrl=0x0501, val=0 → digit0 seg_out=40, digit2 seg_out=40, others C0.
5. Gating: segwrite=1 with segcs=0 (or addr 11) → registers unchanged. Then ctrl=0x0000 → seg_en=FF one cycle later while the counter keeps running.
6. Reset mid-scan: assert reset at index 5, count 2 → next edge: index 0, count 0, registers at reset values, seg_en=FF; a write on the same edge is lost.
